flash_frame_writer: RTL and testbench

//   Parametrised parallel-flash/SRAM write sequencer for frame capture.

---
 rtl/flash_pkg.sv | 29 ++
 rtl/flash_strobe_timer.sv | 31 +++
 rtl/flash_frame_writer.sv | 187 ++++++++++++++++++
 tb/tb_flash_frame_writer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Purpose: shared constants for the flash/SRAM frame writer (state encoding,
//          default bus widths, default strobe wait states, phase-timer width).
// Ports:   none (package).
package flash_pkg;

  localparam int ADDR_W_DEF    = 22;
  localparam int DATA_W_DEF    = 8;
  localparam int SETUP_CYC_DEF = 1;
  localparam int PULSE_CYC_DEF = 2;
  localparam int HOLD_CYC_DEF  = 1;

  // Width of the shared phase down-counter; phases up to 256 cycles.
  localparam int TMR_W = 8;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_WAIT_DATA = 3'd1;
  localparam state_t ST_SETUP     = 3'd2;
  localparam state_t ST_PULSE     = 3'd3;
  localparam state_t ST_HOLD      = 3'd4;
  localparam state_t ST_DONE      = 3'd5;

  // The timer counts down to zero, so a phase of N cycles loads N-1.
  function automatic logic [TMR_W-1:0] tmr_load_val(input int cyc);
    return TMR_W'(cyc - 1);
  endfunction

endpackage

// File: rtl/flash_strobe_timer.sv
// Purpose: loadable down-counter timing one strobe phase (setup, pulse or hold).
// Latency: o_last is high in the final cycle of a phase loaded with N-1.
// Backpressure: none; counts freely and parks at zero.
// Ports: i_clock, i_reset_n, i_load / i_load_val (phase length - 1), o_last.
module flash_strobe_timer
  import flash_pkg::*;
#(
  parameter int W = TMR_W
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_last
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == '0);

endmodule

// File: rtl/flash_frame_writer.sv
// Purpose: writes a stream of words to consecutive flash/SRAM addresses with
//          programmable setup/pulse/hold wait states on active-low ce_n/we_n.
// Latency: 1 + SETUP_CYC + PULSE_CYC + HOLD_CYC cycles per word minimum.
// Backpressure: o_in_ready only in WAIT_DATA; waits indefinitely for i_in_valid.
// Ports: i_start/i_base_addr/i_length launch a transfer; i_in_data/i_in_valid/
//        o_in_ready carry words; o_mem_* drive the memory pins (all registered,
//        oe_n tied inactive); o_busy, o_done, o_words_written report progress.
module flash_frame_writer
  import flash_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int SETUP_CYC = SETUP_CYC_DEF,
  parameter int PULSE_CYC = PULSE_CYC_DEF,
  parameter int HOLD_CYC  = HOLD_CYC_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [DATA_W-1:0] i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_data,
  output logic              o_mem_ce_n,
  output logic              o_mem_we_n,
  output logic              o_mem_oe_n,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_words_written
);

  localparam logic [TMR_W-1:0] SETUP_LD = tmr_load_val(SETUP_CYC);
  localparam logic [TMR_W-1:0] PULSE_LD = tmr_load_val(PULSE_CYC);
  localparam logic [TMR_W-1:0] HOLD_LD  = tmr_load_val(HOLD_CYC);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_words;
  logic [ADDR_W-1:0] w_words_inc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_data;
  logic              r_ce_n;
  logic              r_we_n;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic              w_accept;
  logic              w_xfer;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_last;
  logic              w_ce_n_nxt;
  logic              w_we_n_nxt;
  logic              w_in_ready_nxt;
  logic              w_busy_nxt;
  logic              w_done_nxt;

  // The done cycle is spent in IDLE, so r_done blocks a start landing on it.
  assign w_accept    = (r_state == ST_IDLE) && i_start && !r_done;
  assign w_xfer      = (r_state == ST_WAIT_DATA) && i_in_valid && r_in_ready;
  assign w_words_inc = r_words + 1'b1;

  flash_strobe_timer #(.W(TMR_W)) u_timer (
    .i_clock    (i_clock),
    .i_reset_n  (i_reset_n),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_last     (w_tmr_last)
  );

  // FSM state register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = (i_length == '0) ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_WAIT_DATA: if (w_xfer)     w_state_nxt = ST_SETUP;
      ST_SETUP:     if (w_tmr_last) w_state_nxt = ST_PULSE;
      ST_PULSE:     if (w_tmr_last) w_state_nxt = ST_HOLD;
      ST_HOLD: begin
        if (w_tmr_last) begin
          w_state_nxt = (w_words_inc == r_len) ? ST_DONE : ST_WAIT_DATA;
        end
      end
      ST_DONE:      w_state_nxt = ST_IDLE;
      default:      w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: pin/status values for the coming cycle, plus phase timer reloads.
  // Decoding from the next state lets the output flops line up with r_state.
  always_comb begin
    w_ce_n_nxt     = !(w_state_nxt inside {ST_SETUP, ST_PULSE, ST_HOLD});
    w_we_n_nxt     = (w_state_nxt != ST_PULSE);
    w_in_ready_nxt = (w_state_nxt == ST_WAIT_DATA);
    w_busy_nxt     = (w_state_nxt != ST_IDLE);
    // done follows the DONE state by one cycle, when busy has already dropped
    w_done_nxt     = (r_state == ST_DONE);
    w_tmr_load     = 1'b0;
    w_tmr_val      = '0;
    case (r_state)
      ST_WAIT_DATA: begin
        w_tmr_load = w_xfer;
        w_tmr_val  = SETUP_LD;
      end
      ST_SETUP: begin
        w_tmr_load = w_tmr_last;
        w_tmr_val  = PULSE_LD;
      end
      ST_PULSE: begin
        w_tmr_load = w_tmr_last;
        w_tmr_val  = HOLD_LD;
      end
      default: ;
    endcase
  end

  // Transfer parameters, word counter and the latched address/data pins.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_base     <= '0;
      r_len      <= '0;
      r_words    <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      if (w_accept) begin
        r_base  <= i_base_addr;
        r_len   <= i_length;
        r_words <= '0;
      end else if ((r_state == ST_HOLD) && w_tmr_last) begin
        r_words <= w_words_inc;
      end
      // Address wraps modulo 2**ADDR_W by plain truncation.
      if (w_xfer) begin
        r_mem_addr <= r_base + r_words;
        r_mem_data <= i_in_data;
      end
    end
  end

  // Registered strobes and status.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_ce_n     <= 1'b1;
      r_we_n     <= 1'b1;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_ce_n     <= w_ce_n_nxt;
      r_we_n     <= w_we_n_nxt;
      r_in_ready <= w_in_ready_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  assign o_in_ready      = r_in_ready;
  assign o_mem_addr      = r_mem_addr;
  assign o_mem_data      = r_mem_data;
  assign o_mem_ce_n      = r_ce_n;
  assign o_mem_we_n      = r_we_n;
  assign o_mem_oe_n      = 1'b1;
  assign o_busy          = r_busy;
  assign o_done          = r_done;
  assign o_words_written = r_words;

endmodule

// File: tb/tb_flash_frame_writer.sv
module tb_flash_frame_writer;
  import flash_pkg::*;

  localparam int AW = 22;
  localparam int DW = 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base  = '0;
  logic [AW-1:0] len   = '0;
  logic [DW-1:0] din   = '0;
  logic          vld   = 1'b0;
  logic          rdy;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic          ce_n, we_n, oe_n, busy, done;
  logic [AW-1:0] ww;

  flash_frame_writer dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_start         (start),
    .i_base_addr     (base),
    .i_length        (len),
    .i_in_data       (din),
    .i_in_valid      (vld),
    .o_in_ready      (rdy),
    .o_mem_addr      (addr),
    .o_mem_data      (data),
    .o_mem_ce_n      (ce_n),
    .o_mem_we_n      (we_n),
    .o_mem_oe_n      (oe_n),
    .o_busy          (busy),
    .o_done          (done),
    .o_words_written (ww)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- pin monitor: one record per ce_n-low window ----------------
  logic [AW-1:0] mq_addr[$];
  logic [DW-1:0] mq_data[$];
  int            mq_ce[$];
  int            mq_we[$];
  int            mq_wefirst[$];
  int            mq_start[$];
  bit            mq_stable[$];
  int            done_cnt = 0;
  int            stray_we = 0;
  int            oe_low   = 0;
  int            cyc      = 0;
  bit            in_win   = 0;
  logic [AW-1:0] w_a;
  logic [DW-1:0] w_d;
  int            w_ce, w_we, w_wf, w_st;
  bit            w_ok;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      in_win = 0;
    end else begin
      if (!ce_n) begin
        if (!in_win) begin
          in_win = 1; w_a = addr; w_d = data;
          w_ce = 0; w_we = 0; w_wf = -1; w_st = cyc; w_ok = 1;
        end
        if (addr != w_a || data != w_d) w_ok = 0;
        if (!we_n) begin
          if (w_wf < 0) w_wf = w_ce;
          w_we++;
        end
        w_ce++;
      end else if (in_win) begin
        mq_addr.push_back(w_a); mq_data.push_back(w_d);
        mq_ce.push_back(w_ce); mq_we.push_back(w_we);
        mq_wefirst.push_back(w_wf); mq_start.push_back(w_st);
        mq_stable.push_back(w_ok);
        in_win = 0;
      end
      if (!we_n && ce_n) stray_we++;
      if (!oe_n) oe_low++;
      if (done) done_cnt++;
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference address: base + offset modulo 2**AW, in plain wide arithmetic.
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] b, input int k);
    longint s;
    s = longint'(b) + longint'(k);
    return AW'(s % (longint'(1) << AW));
  endfunction

  task automatic start_xfer(input logic [AW-1:0] b, input logic [AW-1:0] l);
    base = b; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    // Scramble so a design that fails to latch would be caught.
    base = AW'($urandom); len = AW'($urandom);
  endtask

  task automatic push_word(input logic [DW-1:0] d, input int gap);
    int n;
    vld = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (rdy) chk("wait_ce_idle", ce_n, 1);
    end
    if (gap >= 4) begin
      chk("gap_ready_high", rdy, 1);
      chk("gap_ce_high", ce_n, 1);
    end
    din = d; vld = 1'b1; n = 0;
    while (!rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!rdy) chk("ready_timeout", rdy, 1);
    @(negedge clk);
    vld = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_low_at_done", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic run_xfer(input logic [AW-1:0] b, input int l, input int gap,
                          input logic [DW-1:0] dbase, input logic [AW-1:0] exp_last);
    int q0, d0, nw, exp_iv;
    logic [DW-1:0] words[$];
    q0 = mq_addr.size();
    d0 = done_cnt;
    start_xfer(b, AW'(l));
    chk("busy_after_start", busy, 1);
    chk("words_cleared", ww, 0);
    for (int k = 0; k < l; k++) begin
      words.push_back((dbase != '0) ? DW'(dbase + DW'(k)) : DW'($urandom));
      push_word(words[k], (k == 0) ? 0 : gap);
    end
    wait_done(100);
    nw = mq_addr.size() - q0;
    chk("write_count", nw, l);
    exp_iv = (gap + 1 > 5) ? gap + 1 : 5;
    for (int k = 0; k < l && k < nw; k++) begin
      chk($sformatf("addr[%0d]", k), mq_addr[q0+k], model_addr(b, k));
      chk($sformatf("data[%0d]", k), mq_data[q0+k], words[k]);
      chk($sformatf("ce_len[%0d]", k), mq_ce[q0+k], 4);
      chk($sformatf("we_len[%0d]", k), mq_we[q0+k], 2);
      chk($sformatf("we_first[%0d]", k), mq_wefirst[q0+k], 1);
      chk($sformatf("stable[%0d]", k), mq_stable[q0+k], 1);
      if (k > 0) chk($sformatf("interval[%0d]", k), mq_start[q0+k] - mq_start[q0+k-1], exp_iv);
    end
    if (nw == l) chk("last_addr", mq_addr[q0+l-1], exp_last);
    chk("words_written", ww, l);
    chk("done_pulses", done_cnt - d0, 1);
  endtask

  typedef struct {
    logic [AW-1:0] b;
    int            l;
    int            gap;
    logic [DW-1:0] dbase;
    logic [AW-1:0] exp_last;
  } vec_t;

  vec_t vecs[5];

  // ---------------- main sequence ----------------
  initial begin
    int q0, n;
    vecs[0] = '{22'h000100, 3, 0,  8'hA1, 22'h000102};
    vecs[1] = '{22'h3FFFFE, 4, 0,  8'h00, 22'h000001};
    vecs[2] = '{22'h002000, 2, 10, 8'h00, 22'h002001};
    vecs[3] = '{22'h3FFFFF, 1, 3,  8'h00, 22'h3FFFFF};
    vecs[4] = '{22'h000000, 5, 1,  8'h00, 22'h000004};

    #1 rst_n = 1'b0;
    #1;
    chk("rst_ce_n", ce_n, 1);   chk("rst_we_n", we_n, 1);  chk("rst_oe_n", oe_n, 1);
    chk("rst_addr", addr, 0);   chk("rst_data", data, 0);  chk("rst_ready", rdy, 0);
    chk("rst_busy", busy, 0);   chk("rst_done", done, 0);  chk("rst_ww", ww, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 5; i++) begin
      run_xfer(vecs[i].b, vecs[i].l, vecs[i].gap, vecs[i].dbase, vecs[i].exp_last);
    end

    // Zero length: busy one cycle, done two cycles after start, no strobes.
    q0 = mq_addr.size();
    base = 22'h55; len = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_busy_c1", busy, 1);
    chk("len0_done_c1", done, 0);
    chk("len0_ready_c1", rdy, 0);
    @(negedge clk);
    chk("len0_done_c2", done, 1);
    chk("len0_busy_c2", busy, 0);
    // start landing on the done cycle must be ignored
    len = 22'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("len0_done_c3", done, 0);
    chk("start_in_done_ignored", busy, 0);
    repeat (3) @(negedge clk);
    chk("len0_no_writes", mq_addr.size() - q0, 0);
    chk("len0_ww", ww, 0);

    // start re-asserted during PULSE is ignored
    q0 = mq_addr.size();
    start_xfer(22'h40, 22'd2);
    push_word(8'h11, 0);
    n = 0;
    while (we_n && n < 20) begin @(negedge clk); n++; end
    chk("t5_in_pulse", we_n, 0);
    base = 22'h123; len = 22'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    push_word(8'h22, 0);
    wait_done(100);
    chk("t5_count", mq_addr.size() - q0, 2);
    if (mq_addr.size() - q0 == 2) begin
      chk("t5_addr0", mq_addr[q0], 22'h40);
      chk("t5_addr1", mq_addr[q0+1], 22'h41);
      chk("t5_data1", mq_data[q0+1], 8'h22);
    end
    chk("t5_ww", ww, 2);

    // Asynchronous reset mid-PULSE
    start_xfer(22'h200, 22'd3);
    push_word(8'h77, 0);
    n = 0;
    while (we_n && n < 20) begin @(negedge clk); n++; end
    chk("t6_in_pulse", we_n, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_we_n", we_n, 1);   chk("t6_ce_n", ce_n, 1);  chk("t6_oe_n", oe_n, 1);
    chk("t6_addr", addr, 0);   chk("t6_data", data, 0);  chk("t6_ready", rdy, 0);
    chk("t6_busy", busy, 0);   chk("t6_done", done, 0);  chk("t6_ww", ww, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_xfer(22'h300, 2, 0, 8'h00, 22'h301);

    // Randomised transfers against the reference model
    for (int r = 0; r < 8; r++) begin
      logic [AW-1:0] rb;
      int            rl, rg;
      rb = ($urandom_range(0, 2) == 0) ? AW'((1 << AW) - $urandom_range(1, 3)) : AW'($urandom);
      rl = $urandom_range(1, 4);
      rg = $urandom_range(0, 7);
      run_xfer(rb, rl, rg, 8'h00, model_addr(rb, rl - 1));
    end

    chk("no_we_without_ce", stray_we, 0);
    chk("oe_never_low", oe_low, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

endmodule
